mips_muldiv: RTL and testbench
==============================

Name: mips_muldiv

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers, for MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO in the multicycle MIPS datapath.
- Sits beside the ALU; the control unit holds its multiply/divide state until `done` pulses.
- Radix-2 shift-add multiply and restoring divide; signed operations use magnitude plus final sign fix.

Parameters:
- WIDTH, 32, operand/HI/LO width (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rstb  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request new operation; accepted only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  input  WIDTH  multiplicand / dividend (rs); sampled with start.
- b  input  WIDTH  multiplier / divisor (rt); sampled with start.
- hi_wr  input  1  MTHI write strobe.
- lo_wr  input  1  MTLO write strobe.
- wr_data  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  set by DIV/DIVU with b==0; held until next accepted start.
- hi  output  WIDTH  HI register (mult upper half / remainder).
- lo  output  WIDTH  LO register (mult lower half / quotient).

Behaviour:
- Reset (rstb==0 at an edge, any state including mid-operation): state=IDLE, hi=lo=0, busy=0, done=0, div_by_zero=0, counter and internal shift registers cleared; operation in flight is discarded.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 at edge: capture op; capture |a|, |b| (signed ops) or a, b (unsigned ops); record result signs.
  - Clear div_by_zero, then set it if op[1] and b==0.
  - Counter=0; go to CALC.
- CALC: one radix-2 step per cycle for exactly WIDTH cycles; go to FIX when counter==WIDTH-1.
- FIX, signed ops only:
  - Product negated (2*WIDTH bits) if operand signs differ.
  - Quotient negated if dividend and divisor signs differ.
  - Remainder takes dividend sign (truncating division).
- DONE: hi/lo loaded on the edge entering DONE; done=1 for that one cycle; next edge returns to IDLE.
- Latency: done high after exactly WIDTH+2 rising edges counted from the edge that sampled start (34 for WIDTH=32). A new start is accepted in the DONE cycle's following IDLE cycle; back-to-back throughput is one op per WIDTH+3 cycles.
- Width rules:
  - Multiply: full 2*WIDTH product, hi=upper, lo=lower.
  - Most-negative magnitude is handled as unsigned 2^(WIDTH-1), so no overflow occurs in the magnitude path.
  - DIV of -2^(WIDTH-1) by -1: lo=0x80..0, hi=0 (wrap, no trap).
- Divide by zero: lo=all ones, hi=dividend (unsigned view; signed ops still apply FIX sign rules to the magnitude result). div_by_zero=1 from the edge that accepts start.
- start while busy or in DONE: ignored; no queueing; operands not resampled.
- hi_wr/lo_wr:
  - Honoured only in IDLE; write on the next edge.
  - Ignored while busy or in DONE.
  - If hi_wr/lo_wr and start coincide in IDLE, the write happens and the later result overwrites it.
- hi/lo hold their value at all other times; outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, then MULT a=0xFFFFFFFD b=7 -> first: hi=0xFFFFFFFE lo=0x00000001, done exactly 34 edges after start, busy high for 33 cycles; second: hi=0xFFFFFFFF lo=0xFFFFFFEB.
- DIVU 100/7 -> lo=14 hi=2. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD hi=1.
- DIVU 5/0 -> lo=0xFFFFFFFF hi=5, div_by_zero=1 held. Next MULTU 2*3 -> div_by_zero clears on start; hi=0, lo=6.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0, div_by_zero=0. MULT 0x80000000*0x80000000 -> hi=0x40000000 lo=0.
- During MULTU 3*4, pulse start with op=DIVU 9/3 at cycle 5 and hi_wr=1 wr_data=0xAA at cycle 6 -> both ignored; result hi=0 lo=12. In IDLE, hi_wr wr_data=0xAA -> hi=0xAA next edge; lo_wr -> lo updated.
- Start MULTU, drop rstb for one edge at cycle 10 -> busy=0 done=0 hi=lo=0 on that edge; no done pulse afterwards. Then DIVU 9/3 completes normally: lo=3 hi=0.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the multicycle MIPS control path and the multiply/divide unit.
// master drives the requests and MTHI/MTLO writes; slave is the mips_muldiv unit.
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_wr, lo_wr, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_wr, lo_wr, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes and have their signs restored in a single FIX cycle.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rstb,
  mips_muldiv_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) as unsigned.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

  // Multiply step: conditionally add multiplicand to the upper half, then shift right.
  logic [WIDTH:0] mul_sum, mul_acc;

  assign mul_sum = acc_hi_q + {1'b0, opnd_q};
  assign mul_acc = acc_lo_q[0] ? mul_sum : acc_hi_q;

  // Divide step: shift next dividend bit into the remainder and trial-subtract the divisor.
  logic [WIDTH:0] div_shift, div_trial;

  assign div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Sign restoration terms used in the FIX cycle.
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quo_neg, rem_mag, rem_neg;

  assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_fix = neg_q ? (~prod + PW'(1)) : prod;
  assign quo_neg  = ~acc_lo_q + WIDTH'(1);
  assign rem_mag  = acc_hi_q[WIDTH-1:0];
  assign rem_neg  = ~rem_mag + WIDTH'(1);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      is_div_q      <= 1'b0;
      opnd_q        <= '0;
      acc_hi_q      <= '0;
      acc_lo_q      <= '0;
      neg_q         <= 1'b0;
      neg_rem_q     <= 1'b0;
      div_by_zero_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_div_q      <= is_div_d;
      opnd_q        <= opnd_d;
      acc_hi_q      <= acc_hi_d;
      acc_lo_q      <= acc_lo_d;
      neg_q         <= neg_d;
      neg_rem_q     <= neg_rem_d;
      div_by_zero_q <= div_by_zero_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic and iteration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CALC;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; busy/done are decoded from the next state.
  always_comb begin
    is_div_d      = is_div_q;
    opnd_d        = opnd_q;
    acc_hi_d      = acc_hi_q;
    acc_lo_d      = acc_lo_q;
    neg_d         = neg_q;
    neg_rem_d     = neg_rem_q;
    div_by_zero_d = div_by_zero_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    busy_d        = (state_d == S_CALC) || (state_d == S_FIX);
    done_d        = (state_d == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (bus.hi_wr) hi_d = bus.wr_data;
        if (bus.lo_wr) lo_d = bus.wr_data;
        if (bus.start) begin
          is_div_d      = bus.op[1];
          opnd_d        = b_mag;
          acc_hi_d      = '0;
          acc_lo_d      = a_mag;
          neg_d         = a_neg ^ b_neg;
          neg_rem_d     = bus.op[1] & a_neg;
          div_by_zero_d = bus.op[1] && (bus.b == '0);
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_trial[WIDTH] ? div_shift : div_trial;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
          acc_hi_d = {1'b0, mul_acc[WIDTH:1]};
          acc_lo_d = {mul_acc[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q ? quo_neg : acc_lo_q;
          hi_d = neg_rem_q ? rem_neg : rem_mag;
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: expected HI/LO/div_by_zero are queued at launch
// from a behavioural model and compared when done pulses.
module tb_mips_muldiv;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rstb;
  int   pass_cnt;
  int   total_cnt;
  exp_t exp_q[$];

  mips_muldiv_if #(.WIDTH(W)) bus ();

  mips_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    longint unsigned up;
    longint sp;
    r.dbz = op[1] && (b == '0);
    r.hi  = '0;
    r.lo  = '0;
    case (op)
      2'b00: begin
        up   = {32'h0, a} * {32'h0, b};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      2'b01: begin
        sp   = longint'($signed(a)) * longint'($signed(b));
        r.hi = sp[63:32];
        r.lo = sp[31:0];
      end
      2'b10: begin
        if (b == '0) begin
          r.hi = a;
          r.lo = '1;
        end else begin
          r.hi = a % b;
          r.lo = a / b;
        end
      end
      default: begin
        if (b == '0) begin
          r.hi = a;
          r.lo = a[W-1] ? 32'h1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = '0;
          r.lo = 32'h8000_0000;
        end else begin
          r.hi = 32'($signed(a) % $signed(b));
          r.lo = 32'($signed(a) / $signed(b));
        end
      end
    endcase
    return r;
  endfunction

  // Called #1 after an edge while IDLE; returns #1 after the edge that samples start.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges (sampling edge = 1) until done; on success steps one edge into IDLE.
  task automatic wait_done(output int edges, output int busy_cyc, output bit seen, output exp_t got);
    edges    = 1;
    busy_cyc = bus.busy ? 1 : 0;
    seen     = bus.done;
    while (!seen && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cyc++;
      seen = bus.done;
    end
    got.hi  = bus.hi;
    got.lo  = bus.lo;
    got.dbz = bus.div_by_zero;
    if (seen) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_exp(output exp_t want);
    if (exp_q.size() == 0) begin
      want.hi  = 'x;
      want.lo  = 'x;
      want.dbz = 1'bx;
    end else begin
      want = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rstb        = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.hi_wr   = 1'b0;
    bus.lo_wr   = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000)
      $display("FAIL reset_flags: got busy/done/dbz=%b%b%b want 000", bus.busy, bus.done, bus.div_by_zero);
    else pass_cnt++;
    total_cnt++;
    if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h want 00000000", bus.hi);
    else pass_cnt++;
    total_cnt++;
    if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h want 00000000", bus.lo);
    else pass_cnt++;
    rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult();
    logic [1:0]   ops [2] = '{2'b00, 2'b01};
    logic [W-1:0] as  [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    logic [W-1:0] bs  [2] = '{32'hFFFF_FFFF, 32'h0000_0007};
    int edges, bc;
    bit seen;
    exp_t got, want;
    for (int i = 0; i < 2; i++) begin
      launch(ops[i], as[i], bs[i]);
      exp_q.push_back(model(ops[i], as[i], bs[i]));
      wait_done(edges, bc, seen, got);
      pop_exp(want);
      total_cnt++;
      if (!seen || edges != 34) $display("FAIL mult_latency[%0d]: got seen=%0b edges=%0d want edges=34", i, seen, edges);
      else pass_cnt++;
      total_cnt++;
      if (bc != 33) $display("FAIL mult_busy_cycles[%0d]: got %0d want 33", i, bc);
      else pass_cnt++;
      total_cnt++;
      if ({got.hi, got.lo, got.dbz} !== {want.hi, want.lo, want.dbz})
        $display("FAIL mult_result[%0d]: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, got.hi, got.lo, got.dbz, want.hi, want.lo, want.dbz);
      else pass_cnt++;
    end
    // Anchor against literal values in addition to the model.
    total_cnt++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mult_literal: got %h%h want ffffffffffffffeb", bus.hi, bus.lo);
    else pass_cnt++;
  endtask

  task automatic test_div();
    logic [1:0]   ops [3] = '{2'b10, 2'b11, 2'b11};
    logic [W-1:0] as  [3] = '{32'd100, 32'hFFFF_FFF9, 32'd7};
    logic [W-1:0] bs  [3] = '{32'd7, 32'd2, 32'hFFFF_FFFE};
    logic [W-1:0] lit_lo [3] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [W-1:0] lit_hi [3] = '{32'd2, 32'hFFFF_FFFF, 32'd1};
    int edges, bc;
    bit seen;
    exp_t got, want;
    for (int i = 0; i < 3; i++) begin
      launch(ops[i], as[i], bs[i]);
      exp_q.push_back(model(ops[i], as[i], bs[i]));
      wait_done(edges, bc, seen, got);
      pop_exp(want);
      total_cnt++;
      if (!seen || {got.hi, got.lo, got.dbz} !== {want.hi, want.lo, want.dbz})
        $display("FAIL div_result[%0d]: got seen=%0b hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, seen, got.hi, got.lo, got.dbz, want.hi, want.lo, want.dbz);
      else pass_cnt++;
      total_cnt++;
      if ({got.hi, got.lo} !== {lit_hi[i], lit_lo[i]})
        $display("FAIL div_literal[%0d]: got hi=%h lo=%h want hi=%h lo=%h", i, got.hi, got.lo, lit_hi[i], lit_lo[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_by_zero();
    int edges, bc;
    bit seen, held;
    exp_t got, want;
    launch(2'b10, 32'd5, 32'd0);
    exp_q.push_back(model(2'b10, 32'd5, 32'd0));
    total_cnt++;
    if (bus.div_by_zero !== 1'b1) $display("FAIL dbz_set_on_start: got %b want 1", bus.div_by_zero);
    else pass_cnt++;
    wait_done(edges, bc, seen, got);
    pop_exp(want);
    total_cnt++;
    if (!seen || {got.hi, got.lo, got.dbz} !== {want.hi, want.lo, want.dbz})
      $display("FAIL dbz_result: got seen=%0b hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
               seen, got.hi, got.lo, got.dbz, want.hi, want.lo, want.dbz);
    else pass_cnt++;
    held = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.div_by_zero !== 1'b1) held = 1'b0;
    end
    total_cnt++;
    if (!held) $display("FAIL dbz_held: got dropped want held 1");
    else pass_cnt++;
    launch(2'b00, 32'd2, 32'd3);
    exp_q.push_back(model(2'b00, 32'd2, 32'd3));
    total_cnt++;
    if (bus.div_by_zero !== 1'b0) $display("FAIL dbz_clear_on_start: got %b want 0", bus.div_by_zero);
    else pass_cnt++;
    wait_done(edges, bc, seen, got);
    pop_exp(want);
    total_cnt++;
    if (!seen || {got.hi, got.lo, got.dbz} !== {32'd0, 32'd6, 1'b0} || {got.hi, got.lo} !== {want.hi, want.lo})
      $display("FAIL dbz_next_mult: got seen=%0b hi=%h lo=%h dbz=%b want hi=0 lo=6 dbz=0", seen, got.hi, got.lo, got.dbz);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    logic [1:0]   ops [2] = '{2'b11, 2'b01};
    logic [W-1:0] as  [2] = '{32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] bs  [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] lit_hi [2] = '{32'h0, 32'h4000_0000};
    logic [W-1:0] lit_lo [2] = '{32'h8000_0000, 32'h0};
    int edges, bc;
    bit seen;
    exp_t got, want;
    for (int i = 0; i < 2; i++) begin
      launch(ops[i], as[i], bs[i]);
      exp_q.push_back(model(ops[i], as[i], bs[i]));
      wait_done(edges, bc, seen, got);
      pop_exp(want);
      total_cnt++;
      if (!seen || {got.hi, got.lo, got.dbz} !== {lit_hi[i], lit_lo[i], 1'b0} || {got.hi, got.lo} !== {want.hi, want.lo})
        $display("FAIL boundary[%0d]: got seen=%0b hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=0",
                 i, seen, got.hi, got.lo, got.dbz, lit_hi[i], lit_lo[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_while_busy();
    int edges;
    bit seen, quiet;
    exp_t want;
    launch(2'b00, 32'd3, 32'd4);
    exp_q.push_back(model(2'b00, 32'd3, 32'd4));
    edges = 1;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      bus.start = (edges == 4);
      if (edges == 4) begin
        bus.op = 2'b10;
        bus.a  = 32'd9;
        bus.b  = 32'd3;
      end
      bus.hi_wr   = (edges == 5);
      bus.wr_data = 32'hAA;
      @(posedge clk);
      #1;
      edges++;
      seen = bus.done;
    end
    bus.start = 1'b0;
    bus.hi_wr = 1'b0;
    pop_exp(want);
    total_cnt++;
    if (!seen || edges != 34 || {bus.hi, bus.lo} !== {want.hi, want.lo} || {bus.hi, bus.lo} !== {32'd0, 32'd12})
      $display("FAIL ignore_busy: got seen=%0b edges=%0d hi=%h lo=%h want edges=34 hi=0 lo=c", seen, edges, bus.hi, bus.lo);
    else pass_cnt++;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) quiet = 1'b0;
    end
    total_cnt++;
    if (!quiet) $display("FAIL ignore_no_queue: got activity after done want idle");
    else pass_cnt++;
  endtask

  task automatic test_mthi_mtlo();
    logic [W-1:0] lo_before;
    lo_before   = bus.lo;
    bus.hi_wr   = 1'b1;
    bus.wr_data = 32'hAA;
    @(posedge clk);
    #1;
    bus.hi_wr = 1'b0;
    total_cnt++;
    if (bus.hi !== 32'hAA || bus.lo !== lo_before)
      $display("FAIL mthi: got hi=%h lo=%h want hi=000000aa lo=%h", bus.hi, bus.lo, lo_before);
    else pass_cnt++;
    bus.lo_wr   = 1'b1;
    bus.wr_data = 32'h5555_1234;
    @(posedge clk);
    #1;
    bus.lo_wr = 1'b0;
    total_cnt++;
    if (bus.lo !== 32'h5555_1234 || bus.hi !== 32'hAA)
      $display("FAIL mtlo: got hi=%h lo=%h want hi=000000aa lo=55551234", bus.hi, bus.lo);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int edges, bc;
    bit seen, quiet;
    exp_t got, want;
    launch(2'b00, 32'h1234, 32'h5678);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    rstb = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi !== 32'h0 || bus.lo !== 32'h0)
      $display("FAIL reset_mid_op: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
    else pass_cnt++;
    quiet = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    total_cnt++;
    if (!quiet) $display("FAIL reset_discard: got done/busy after reset want none");
    else pass_cnt++;
    launch(2'b10, 32'd9, 32'd3);
    exp_q.push_back(model(2'b10, 32'd9, 32'd3));
    wait_done(edges, bc, seen, got);
    pop_exp(want);
    total_cnt++;
    if (!seen || {got.hi, got.lo, got.dbz} !== {want.hi, want.lo, want.dbz} || got.lo !== 32'd3)
      $display("FAIL reset_recover: got seen=%0b hi=%h lo=%h want hi=0 lo=3", seen, got.hi, got.lo);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int edges, bc;
    bit seen;
    exp_t got, want;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : $urandom;
      launch(op, a, b);
      exp_q.push_back(model(op, a, b));
      wait_done(edges, bc, seen, got);
      pop_exp(want);
      total_cnt++;
      if (!seen || edges != 34 || {got.hi, got.lo, got.dbz} !== {want.hi, want.lo, want.dbz})
        $display("FAIL back_to_back[%0d] op=%0d a=%h b=%h: got seen=%0b edges=%0d hi=%h lo=%h dbz=%b want edges=34 hi=%h lo=%h dbz=%b",
                 i, op, a, b, seen, edges, got.hi, got.lo, got.dbz, want.hi, want.lo, want.dbz);
      else pass_cnt++;
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_boundary();
    test_ignore_while_busy();
    test_mthi_mtlo();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
